// File: rtl/display_pkg.sv
// display_pkg: shared width default, register selects and scan states for display_timing_ctrl
package display_pkg;
  localparam int CNT_W_DEF = 10;
  localparam logic [2:0] SEL_HB = 3'd0;
  localparam logic [2:0] SEL_VB = 3'd1;
  localparam logic [2:0] SEL_AIP = 3'd2;
  localparam logic [2:0] SEL_AIL = 3'd3;
  localparam logic [2:0] SEL_CTRL = 3'd4;
  typedef enum logic [1:0] {STOPPED, H_ACT, H_BLK} state_t;
endpackage

// File: rtl/display_timing_ctrl_cfg_regs.sv
// display_cfg_regs: shadow/live timing registers, write decode, run bit and cfg_err (FRAME_CNT_EN adds cnt_clr)
module display_cfg_regs
  import display_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_HB = 16,
  parameter int DEF_VB = 4,
  parameter int DEF_AIP = 64,
  parameter int DEF_AIL = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic [31:0]      wdata,
  input  logic             commit,
  output logic [CNT_W-1:0] hb,
  output logic [CNT_W-1:0] vb,
  output logic [CNT_W-1:0] aip,
  output logic [CNT_W-1:0] ail,
  output logic             run_nxt,
  output logic             cfg_err
`ifdef FRAME_CNT_EN
  , output logic           cnt_clr
`endif
);
  logic [CNT_W-1:0] sh_hb, sh_vb, sh_aip, sh_ail, val;
  logic [2:0] sel;
  logic run, valid, wr, unused_bits;
  assign sel = wdata[31:29];
  assign val = wdata[CNT_W-1:0];
  assign unused_bits = ^wdata[28:CNT_W];
  assign valid = sel <= SEL_CTRL && !((sel == SEL_AIP || sel == SEL_AIL) && val == '0);
  assign wr = cs && valid;
  // The FSM reacts to a run change on the same edge that latches it.
  assign run_nxt = (cs && sel == SEL_CTRL) ? val[0] : run;
`ifdef FRAME_CNT_EN
  assign cnt_clr = cs && sel == SEL_CTRL && val[1];
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_hb <= CNT_W'(DEF_HB);
      sh_vb <= CNT_W'(DEF_VB);
      sh_aip <= CNT_W'(DEF_AIP);
      sh_ail <= CNT_W'(DEF_AIL);
      hb <= CNT_W'(DEF_HB);
      vb <= CNT_W'(DEF_VB);
      aip <= CNT_W'(DEF_AIP);
      ail <= CNT_W'(DEF_AIL);
      run <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cs && !valid;
      run <= run_nxt;
      if (wr && sel == SEL_HB) sh_hb <= val;
      if (wr && sel == SEL_VB) sh_vb <= val;
      if (wr && sel == SEL_AIP) sh_aip <= val;
      if (wr && sel == SEL_AIL) sh_ail <= val;
      // Live takes the pre-write shadow, so a colliding write lands a frame later.
      if (commit) begin
        hb <= sh_hb;
        vb <= sh_vb;
        aip <= sh_aip;
        ail <= sh_ail;
      end
    end
  end
endmodule

// File: rtl/display_timing_ctrl.sv
// display_timing_ctrl: pixel/line scan FSM with frame-boundary commit of timing registers
// Optional FRAME_CNT_EN adds a 16-bit frame_cnt output.
module display_timing_ctrl
  import display_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_HB = 16,
  parameter int DEF_VB = 4,
  parameter int DEF_AIP = 64,
  parameter int DEF_AIL = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CSDisplay,
  input  logic [31:0]      WData,
  output logic [CNT_W-1:0] HBOut,
  output logic [CNT_W-1:0] VBOut,
  output logic [CNT_W-1:0] AIPOut,
  output logic [CNT_W-1:0] AILOut,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             active,
  output logic             hblank,
  output logic             vblank,
  output logic             line_start,
  output logic             frame_start,
  output logic             cfg_err
`ifdef FRAME_CNT_EN
  , output logic [15:0]    frame_cnt
`endif
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] x_n, y_n;
  logic [CNT_W:0] frame_lines;
  logic run_nxt, commit, last_act, line_end, frame_end;
  logic act_n, hbl_n, vbl_n, ls_n, fs_n;
`ifdef FRAME_CNT_EN
  logic cnt_clr;
`endif
  display_cfg_regs #(
    .CNT_W(CNT_W), .DEF_HB(DEF_HB), .DEF_VB(DEF_VB), .DEF_AIP(DEF_AIP), .DEF_AIL(DEF_AIL)
  ) u_cfg (
    .clk(clk), .reset(reset), .cs(CSDisplay), .wdata(WData), .commit(commit),
    .hb(HBOut), .vb(VBOut), .aip(AIPOut), .ail(AILOut),
    .run_nxt(run_nxt), .cfg_err(cfg_err)
`ifdef FRAME_CNT_EN
    , .cnt_clr(cnt_clr)
`endif
  );
  assign frame_lines = {1'b0, AILOut} + {1'b0, VBOut};
  assign last_act = state == H_ACT && pix_x == AIPOut - ONE;
  assign line_end = (last_act && HBOut == '0) || (state == H_BLK && pix_x == HBOut - ONE);
  assign frame_end = line_end && {1'b0, pix_y} == frame_lines - (CNT_W + 1)'(1);
  assign commit = state == STOPPED || !run_nxt || frame_end;
  always_comb begin
    state_n = state;
    x_n = pix_x + ONE;
    y_n = pix_y;
    ls_n = 1'b0;
    fs_n = 1'b0;
    if (!run_nxt) begin
      state_n = STOPPED;
      x_n = '0;
      y_n = '0;
    end else if (state == STOPPED) begin
      state_n = H_ACT;
      x_n = '0;
      y_n = '0;
      ls_n = 1'b1;
      fs_n = 1'b1;
    end else if (line_end) begin
      state_n = H_ACT;
      x_n = '0;
      y_n = frame_end ? '0 : pix_y + ONE;
      ls_n = 1'b1;
      fs_n = frame_end;
    end else if (last_act) begin
      state_n = H_BLK;
      x_n = '0;
    end
    vbl_n = state_n != STOPPED && y_n >= AILOut;
    act_n = state_n == H_ACT && !vbl_n;
    hbl_n = state_n == H_BLK;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STOPPED;
      pix_x <= '0;
      pix_y <= '0;
      active <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      pix_x <= x_n;
      pix_y <= y_n;
      active <= act_n;
      hblank <= hbl_n;
      vblank <= vbl_n;
      line_start <= ls_n;
      frame_start <= fs_n;
    end
  end
`ifdef FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (cnt_clr) frame_cnt <= '0;
    else if (fs_n) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/display_timing_ctrl.md
Name: display_timing_ctrl

Overview:
Sequencer and configurator for the display datapath.
- Accepts 32-bit register writes (WData, CSDisplay) into shadow timing registers.
- Commits the shadow registers to the live HBOut/VBOut/AIPOut/AILOut values that drive the DataPath, at frame boundaries only.
- Runs the pixel/line scan FSM that produces active, blank and coordinate strobes for the pixel pipeline.

Parameters:
CNT_W, 10, width of every timing field and counter
DEF_HB, 16, reset value of horizontal blank length (pixels)
DEF_VB, 4, reset value of vertical blank length (lines)
DEF_AIP, 64, reset value of active pixels per line
DEF_AIL, 48, reset value of active lines per frame

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
CSDisplay  in  1  write strobe, one write per high cycle
WData  in  32  [31:29] register select, [CNT_W-1:0] value
HBOut  out  CNT_W  live horizontal blank length
VBOut  out  CNT_W  live vertical blank length
AIPOut  out  CNT_W  live active pixels per line
AILOut  out  CNT_W  live active lines per frame
pix_x  out  CNT_W  horizontal position within the current segment
pix_y  out  CNT_W  line index within the frame
active  out  1  active pixel cycle
hblank  out  1  horizontal blank cycle
vblank  out  1  line index is at or beyond AILOut
line_start  out  1  pulse on pixel 0 of every line
frame_start  out  1  pulse on pixel 0 of line 0
cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset:
  - Shadow and live registers load the DEF_* values.
  - run = 0; state STOPPED.
  - pix_x, pix_y = 0; all strobes = 0.
  - All outputs are registered.
- Register select (WData[31:29]):
  - 000 HB, 001 VB, 010 AIP, 011 AIL: write the shadow register.
  - 100 CTRL: bit0 = run.
  - Any other select, or value 0 written to AIP or AIL: cfg_err pulses the next cycle and nothing changes.
  - HB = 0 and VB = 0 are legal; the matching blank segment is skipped.
- FSM states: STOPPED, H_ACT, H_BLK.
  - STOPPED: shadow registers are copied to live every cycle. When run=1 is sampled: next cycle H_ACT, pix_x=0, pix_y=0, frame_start=1, line_start=1.
  - H_ACT: pix_x counts 0..AIPOut-1. After the last pixel, go to H_BLK with pix_x=0, or straight to the next line if HBOut=0.
  - H_BLK: pix_x counts 0..HBOut-1. After the last cycle, pix_y increments and the FSM returns to H_ACT with line_start=1.
- Line timing: one line lasts AIPOut+HBOut cycles.
- Frame timing:
  - Lines 0..AILOut-1 are visible.
  - Lines AILOut..AILOut+VBOut-1 assert vblank.
  - After the last line, pix_y wraps to 0 and frame_start=1.
- Strobes: active = H_ACT and not vblank. hblank = H_BLK.
- Commit: on the final cycle of a frame, shadow is copied to live, so new values take effect on the frame_start cycle.
- Simultaneous write and commit: the commit uses the pre-write shadow value; the written value is held for the next frame.
- run cleared mid-frame: next cycle STOPPED, counters 0, strobes 0. The pending shadow commits immediately.
- Reset mid-frame: immediate return to reset values (asynchronous).
- CTRL write while running with run=1 has no effect.

Optional Feature:
FRAME_CNT_EN
- Defined: adds output frame_cnt, 16 bits. It resets to 0, increments on every frame_start and wraps at 0xFFFF to 0. A CTRL write with bit1=1 clears it; clear wins over a same-cycle increment.
- Undefined: the port and its logic are absent.

Decomposition:
Package display_pkg holds:
- the CNT_W default;
- register-select constants (SEL_HB, SEL_VB, SEL_AIP, SEL_AIL, SEL_CTRL);
- the FSM state enum.

Natural sub-module: display_cfg_regs, holding shadow/live registers, write decode, cfg_err and commit. The FSM and counters stay in the top.

Test Plan:
1. Reset then no writes -> HBOut=16, VBOut=4, AIPOut=64, AILOut=48; pix_x=0; all strobes 0; state STOPPED.
2. Write AIP=4, HB=2, AIL=3, VB=1, then CTRL=1 -> line every 6 cycles; active 4 cycles, hblank 2 cycles; vblank on line 3; frame_start every 24 cycles.
3. Running 4/2/3/1, write AIP=8 mid-frame -> AIPOut stays 4 until the next frame_start, then 8; next frame lasts 40 cycles.
4. Write select 101 and AIL=0 -> cfg_err pulses once each; shadow unchanged; timing unaffected.
5. CTRL=0 on line 1 pixel 2 -> next cycle STOPPED with all strobes 0; re-enable gives frame_start with pix_y=0.
6. Write coinciding with the frame's final cycle -> live registers take the old shadow; the new value appears one frame later. With FRAME_CNT_EN, frame_cnt equals the number of frames elapsed.
